// File: rtl/lsu_store_queue.sv
// lsu_store_queue: in-order store queue between the LSU execute stage and the DCache write port.
// Stores are held speculatively until the ROB commits them. Committed stores drain to the DCache
// in program order. A backend flush discards every store that is not yet committed.
//
// Configuration macro: LSU_STORE_QUEUE_FORWARD_EN
//   defined   -> per-byte store-to-load forwarding from the youngest matching entry
//   undefined -> no forwarding; any address match on a load forces a replay
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            drop all uncommitted (pending) entries
//   push_*             new store from execute; push_ready_o = !full && !flush
//   commit_num_i       number of oldest pending stores retired this cycle
//   drain_*            head entry presented to the DCache (valid/ready handshake)
//   ld_addr_i/bmask_i  load probe; ld_fwd_mask_o/data_o/conflict_o are the probe result
//   empty_o, full_o    occupancy flags from registered pointers only
module lsu_store_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [ADDR_WIDTH-1:0]              push_addr_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic [DATA_WIDTH/8-1:0]            push_wstrb_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]  commit_num_i,
  output logic                               drain_valid_o,
  input  logic                               drain_ready_i,
  output logic [ADDR_WIDTH-1:0]              drain_addr_o,
  output logic [DATA_WIDTH-1:0]              drain_data_o,
  output logic [DATA_WIDTH/8-1:0]            drain_wstrb_o,
  input  logic [ADDR_WIDTH-1:0]              ld_addr_i,
  input  logic [DATA_WIDTH/8-1:0]            ld_bmask_i,
  output logic [DATA_WIDTH/8-1:0]            ld_fwd_mask_o,
  output logic [DATA_WIDTH-1:0]              ld_fwd_data_o,
  output logic                               ld_conflict_o,
  output logic                               empty_o,
  output logic                               full_o
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned PtrW  = IdxW + 1;
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  // Entry payload is not reset; validity comes from the pointers alone.
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [StrbW-1:0]      wstrb_q [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [PtrW-1:0] occupancy, pending, commit_amt;
  logic            push_fire, drain_fire;

  assign occupancy     = tail_q - head_q;
  assign pending       = tail_q - cmt_q;
  assign full_o        = occupancy == PtrW'(DEPTH);
  assign empty_o       = tail_q == head_q;
  assign push_ready_o  = !full_o && !flush_i;
  assign push_fire     = push_valid_i && push_ready_o;
  assign drain_valid_o = cmt_q != head_q;
  assign drain_fire    = drain_valid_o && drain_ready_i;

  assign drain_addr_o  = addr_q[head_q[IdxW-1:0]];
  assign drain_data_o  = data_q[head_q[IdxW-1:0]];
  assign drain_wstrb_o = wstrb_q[head_q[IdxW-1:0]];

  // Commit never advances past stores that were pending at the start of the cycle.
  always_comb begin
    commit_amt = pending;
    if (int'(commit_num_i) < int'(pending)) commit_amt = PtrW'(commit_num_i);
  end

  always_comb begin
    head_d = head_q + PtrW'(drain_fire);
    cmt_d  = cmt_q + commit_amt;
    // Flush rewinds tail onto the post-commit boundary; a same-cycle push is lost.
    tail_d = flush_i ? cmt_d : tail_q + PtrW'(push_fire);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      addr_q[tail_q[IdxW-1:0]]  <= push_addr_i;
      data_q[tail_q[IdxW-1:0]]  <= push_data_i;
      wstrb_q[tail_q[IdxW-1:0]] <= push_wstrb_i;
    end
  end

  // Load probe, walked by age: slot k is the k-th oldest valid entry.
  logic [IdxW-1:0]  age_idx   [DEPTH];
  logic [DEPTH-1:0] age_match;
  logic             any_match;

  always_comb begin
    age_match = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      age_idx[k]   = head_q[IdxW-1:0] + IdxW'(k);
      age_match[k] = (PtrW'(k) < occupancy) &&
                     (addr_q[age_idx[k]][ADDR_WIDTH-1:OffW] == ld_addr_i[ADDR_WIDTH-1:OffW]);
    end
  end

  assign any_match = |age_match;

`ifdef LSU_STORE_QUEUE_FORWARD_EN
  logic [StrbW-1:0]      cover;
  logic [DATA_WIDTH-1:0] cover_data;

  // Oldest to youngest, so a younger store overwrites an older one lane by lane.
  always_comb begin
    cover      = '0;
    cover_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (age_match[k]) begin
        for (int unsigned l = 0; l < StrbW; l++) begin
          if (wstrb_q[age_idx[k]][l]) begin
            cover[l]             = 1'b1;
            cover_data[8*l +: 8] = data_q[age_idx[k]][8*l +: 8];
          end
        end
      end
    end
  end

  assign ld_fwd_mask_o = cover & ld_bmask_i;

  always_comb begin
    ld_fwd_data_o = '0;
    for (int unsigned l = 0; l < StrbW; l++) begin
      if (ld_fwd_mask_o[l]) ld_fwd_data_o[8*l +: 8] = cover_data[8*l +: 8];
    end
  end

  assign ld_conflict_o = any_match && |(ld_bmask_i & ~ld_fwd_mask_o);
`else
  assign ld_fwd_mask_o = '0;
  assign ld_fwd_data_o = '0;
  assign ld_conflict_o = any_match;
`endif

  // Byte offset of the probe and (without forwarding) the byte mask do not affect matching.
  logic unused_ld;
  assign unused_ld = ^{ld_addr_i, ld_bmask_i};

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (int'(commit_num_i) <= int'(pending))
        else $error("commit_num exceeds pending store count");
    end
  end
`endif

endmodule

// File: tb/tb_lsu_store_queue.sv
module tb_lsu_store_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush, push_valid, push_ready;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic [SW-1:0] push_wstrb;
  logic [1:0]    commit_num;
  logic          drain_valid, drain_ready;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;
  logic [SW-1:0] drain_wstrb;
  logic [AW-1:0] ld_addr;
  logic [SW-1:0] ld_bmask, ld_fwd_mask;
  logic [DW-1:0] ld_fwd_data;
  logic          ld_conflict, empty, full;

  lsu_store_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMMIT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_addr_i(push_addr),
    .push_data_i(push_data), .push_wstrb_i(push_wstrb), .commit_num_i(commit_num),
    .drain_valid_o(drain_valid), .drain_ready_i(drain_ready), .drain_addr_o(drain_addr),
    .drain_data_o(drain_data), .drain_wstrb_o(drain_wstrb), .ld_addr_i(ld_addr),
    .ld_bmask_i(ld_bmask), .ld_fwd_mask_o(ld_fwd_mask), .ld_fwd_data_o(ld_fwd_data),
    .ld_conflict_o(ld_conflict), .empty_o(empty), .full_o(full)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] wstrb;
  } st_t;

  // Reference: committed stores (oldest first) and pending stores (oldest first).
  st_t cq[$];
  st_t pq[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [AW-1:0] addrs [3] = '{32'h200, 32'h204, 32'h300};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    flush = 0; push_valid = 0; push_addr = '0; push_data = '0; push_wstrb = '0;
    commit_num = '0; drain_ready = 0; ld_addr = '0; ld_bmask = '0;
  endtask

  task automatic set_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    push_valid = 1; push_addr = a; push_data = d; push_wstrb = s;
  endtask

  task automatic model_probe(output logic [SW-1:0] m, output logic [DW-1:0] d, output logic c);
    st_t all[$];
    logic any;
    logic [SW-1:0] cov;
    logic [DW-1:0] byt;
    any = 0; cov = '0; byt = '0; m = '0; d = '0;
    foreach (cq[i]) all.push_back(cq[i]);
    foreach (pq[i]) all.push_back(pq[i]);
    for (int i = 0; i < all.size(); i++) begin
      if (all[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin
        any = 1;
        for (int l = 0; l < SW; l++)
          if (all[i].wstrb[l]) begin cov[l] = 1; byt[8*l +: 8] = all[i].data[8*l +: 8]; end
      end
    end
`ifdef LSU_STORE_QUEUE_FORWARD_EN
    m = cov & ld_bmask;
    for (int l = 0; l < SW; l++) if (m[l]) d[8*l +: 8] = byt[8*l +: 8];
    c = any && ((ld_bmask & ~m) != '0);
`else
    c = any;
`endif
  endtask

  task automatic check_model();
    int unsigned total;
    logic [SW-1:0] m;
    logic [DW-1:0] d;
    logic c;
    total = cq.size() + pq.size();
    chk("empty", empty, total == 0);
    chk("full", full, total == DEPTH);
    chk("push_ready", push_ready, (total != DEPTH) && !flush);
    chk("drain_valid", drain_valid, cq.size() != 0);
    if (cq.size() != 0) begin
      chk("drain_addr", drain_addr, cq[0].addr);
      chk("drain_data", drain_data, cq[0].data);
      chk("drain_wstrb", drain_wstrb, cq[0].wstrb);
    end
    model_probe(m, d, c);
    chk("ld_fwd_mask", ld_fwd_mask, m);
    chk("ld_fwd_data", ld_fwd_data, d);
    chk("ld_conflict", ld_conflict, c);
  endtask

  task automatic update_model();
    int unsigned n;
    bit fire;
    st_t e;
    fire = push_valid && (cq.size() + pq.size() < DEPTH) && !flush;
    if (drain_ready && cq.size() != 0) void'(cq.pop_front());
    n = commit_num;
    if (n > pq.size()) n = pq.size();
    repeat (n) cq.push_back(pq.pop_front());
    if (flush) pq.delete();
    else if (fire) begin
      e.addr = push_addr; e.data = push_data; e.wstrb = push_wstrb;
      pq.push_back(e);
    end
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+3/4.
  task automatic step();
    #2;
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    int nxt;
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    cq.delete(); pq.delete();

    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_fwd_mask", ld_fwd_mask, 0);
    chk("rst_fwd_data", ld_fwd_data, 0);
    chk("rst_conflict", ld_conflict, 0);

    // Fill without committing.
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_push(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
      step();
    end
    set_idle(); #1;
    chk("fill_full", full, 1);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_drain_valid", drain_valid, 0);

    // Commit two, drain them back to back.
    commit_num = 2; drain_ready = 1;
    step();
    commit_num = 0; #1;
    chk("cmt_drain0_valid", drain_valid, 1);
    chk("cmt_drain0_addr", drain_addr, 32'h100);
    step();
    #1;
    chk("cmt_drain1_addr", drain_addr, 32'h104);
    chk("cmt_ready_after_drain", push_ready, 1);
    step();
    #1;
    chk("cmt_drain_stops", drain_valid, 0);
    commit_num = 2;
    step();
    commit_num = 0;
    repeat (3) step();
    #1;
    chk("cmt_empty", empty, 1);

    // Flush in the same cycle as a commit keeps only the committed store.
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_push(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      step();
    end
    set_idle(); commit_num = 1; flush = 1;
    step();
    set_idle(); drain_ready = 1; #1;
    chk("flush_keep_valid", drain_valid, 1);
    chk("flush_keep_addr", drain_addr, 32'h400);
    step();
    #1;
    chk("flush_empty", empty, 1);
    step();

    // Continuous push/commit/drain across pointer wrap.
    nxt = 0;
    for (int i = 0; i < 10; i++) begin
      set_idle(); set_push(32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 4'hF);
      commit_num = (pq.size() > 0) ? 2'd1 : 2'd0;
      drain_ready = 1; #1;
      chk("wrap_no_full", full, 0);
      if (cq.size() != 0) begin
        chk("wrap_order", drain_addr, 32'h500 + 32'(4 * nxt));
        nxt++;
      end
      step();
    end
    for (int i = 0; i < 12; i++) begin
      set_idle(); drain_ready = 1;
      commit_num = 2'((pq.size() < 2) ? pq.size() : 2);
      #1;
      if (cq.size() != 0) begin
        chk("wrap_order", drain_addr, 32'h500 + 32'(4 * nxt));
        nxt++;
      end
      step();
    end
    chk("wrap_count", nxt, 10);

    // Forwarding probe.
    set_idle(); set_push(32'h200, 32'h0000BEEF, 4'b0011); step();
    set_idle(); set_push(32'h200, 32'h0000AA00, 4'b0010); step();
    set_idle(); ld_addr = 32'h200; ld_bmask = 4'b0011; #1;
`ifdef LSU_STORE_QUEUE_FORWARD_EN
    chk("fwd_mask", ld_fwd_mask, 4'b0011);
    chk("fwd_data", ld_fwd_data, 32'h0000AAEF);
    chk("fwd_conflict", ld_conflict, 0);
`else
    chk("nofwd_mask", ld_fwd_mask, 0);
    chk("nofwd_data", ld_fwd_data, 0);
    chk("nofwd_conflict", ld_conflict, 1);
`endif
    step();
    ld_bmask = 4'hF; #1;
    chk("fwd_partial_conflict", ld_conflict, 1);
    step();
    ld_addr = 32'h300; #1;
    chk("fwd_other_addr", ld_conflict, 0);
    step();
    set_idle(); flush = 1; step();
    set_idle(); step();

    // Randomized traffic against the reference queues.
    for (int cyc = 0; cyc < 400; cyc++) begin
      int unsigned pend;
      pend = pq.size();
      set_idle();
      push_valid  = ($urandom_range(0, 3) != 0);
      push_addr   = addrs[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
      push_data   = $urandom;
      push_wstrb  = 4'($urandom_range(1, 15));
      commit_num  = 2'($urandom_range(0, (pend < 2) ? pend : 2));
      drain_ready = ($urandom_range(0, 1) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      ld_addr     = addrs[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
      ld_bmask    = 4'($urandom_range(0, 15));
      step();
    end
    set_idle();
    step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/lsu_store_queue.md
Name: lsu_store_queue

Overview:
- Parametrised in-order store queue between LSU execute stage and DCache write port; generalises the fixed 4-entry store buffer to configurable depth, data width and commit width.
- Holds stores speculatively until ROB commit, drains committed stores to DCache in order, discards uncommitted stores on backend flush.
- Optional store-to-load byte forwarding.

Parameters:
DEPTH, 4, number of entries; power of two, >=2 (matches LSU_STORE_QUEU_SIZE)
ADDR_WIDTH, 32, store address width
DATA_WIDTH, 32, store data width; must be a multiple of 8
COMMIT_WIDTH, 2, maximum stores committed per cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  backend flush; discards all uncommitted entries
push_valid  in  1  new store from execute stage
push_ready  out  1  queue can accept a store this cycle
push_addr  in  ADDR_WIDTH  store address
push_data  in  DATA_WIDTH  store data, already lane-aligned
push_wstrb  in  DATA_WIDTH/8  byte enables
commit_num  in  $clog2(COMMIT_WIDTH+1)  number of oldest pending stores retired this cycle
drain_valid  out  1  oldest committed store presented to DCache
drain_ready  in  1  DCache accepts the drain
drain_addr  out  ADDR_WIDTH  address of head entry
drain_data  out  DATA_WIDTH  data of head entry
drain_wstrb  out  DATA_WIDTH/8  strobe of head entry
ld_addr  in  ADDR_WIDTH  load address probe
ld_bmask  in  DATA_WIDTH/8  bytes the load needs
ld_fwd_mask  out  DATA_WIDTH/8  bytes supplied by the queue
ld_fwd_data  out  DATA_WIDTH  forwarded bytes
ld_conflict  out  1  load must replay
empty  out  1  no valid entries
full  out  1  all DEPTH entries valid

Behaviour:
- Circular buffer with three pointers of width $clog2(DEPTH)+1 (extra wrap bit): head (oldest, next drain), cmt (first uncommitted), tail (next free). Region head..cmt = COMMITTED; cmt..tail = PENDING.
- Reset: all pointers 0; empty=1, full=0, push_ready=1, drain_valid=0, ld_fwd_mask=0, ld_fwd_data=0, ld_conflict=0. Entry payload not reset.
- full = (tail - head) == DEPTH; empty = tail == head. Both from registered pointers only.
- push_ready = !full && !flush. A push occurs when push_valid && push_ready; entry written at tail; tail += 1 next cycle. A push does not rely on a same-cycle drain freeing space.
- Commit: cmt += commit_num, clamped to the PENDING count at cycle start. A store pushed in cycle N can be committed from cycle N+1 onward. commit_num > PENDING is a protocol error and fires an assertion under simulation.
- Drain: drain_valid = (cmt != head); outputs driven combinationally from the head entry. On drain_valid && drain_ready, head += 1. A store committed in cycle N is drainable from cycle N+1. drain_valid and payload hold stable until accepted.
- Flush: tail <= cmt, computed after that cycle's commit is applied. Committed entries survive and keep draining. Any push in the flush cycle is dropped.
- Simultaneous push, commit, drain and flush in one cycle: all pointer updates apply independently, with flush overriding tail.
- Pointer arithmetic wraps modulo 2*DEPTH. Index = low $clog2(DEPTH) bits.
- Load probe (combinational): an entry matches when it is valid and ld_addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)] equals its word address.

Optional Feature:
LSU_STORE_QUEUE_FORWARD_EN
- Defined: for each byte lane, take the youngest matching entry whose wstrb has that lane set. ld_fwd_mask[i] = that lane is covered AND ld_bmask[i]. ld_fwd_data lane = that entry's byte, 0 elsewhere. ld_conflict = any match && (ld_bmask & ~ld_fwd_mask) != 0.
- Undefined: ld_fwd_mask=0, ld_fwd_data=0, ld_conflict = any match, regardless of lanes.

Test Plan:
- Reset, push 4 stores (addr 0x100,0x104,0x108,0x10C), no commit -> full=1, push_ready=0, drain_valid=0.
- commit_num=2 next cycle, drain_ready=1 -> drain of 0x100 then 0x104 on consecutive cycles; drain_valid drops after 2 drains; push_ready=1 once head advances.
- Push 3 stores, commit 1, flush same cycle as commit -> queue keeps 1 entry (tail=cmt); drains it; empty=1 afterwards.
- Wrap: DEPTH=4, push/commit/drain 10 stores continuously -> drain order matches push order, no overflow; full never asserts with drain_ready=1.
- Forward (macro on): store 0x200 wstrb=0011 data 0x0000BEEF, then store 0x200 wstrb=0010 data 0x0000AA00; load 0x200 bmask=0011 -> ld_fwd_mask=0011, ld_fwd_data=0x0000AAEF, ld_conflict=0. Load bmask=1111 -> ld_conflict=1.
- Macro off, same stores, load 0x200 -> ld_fwd_mask=0, ld_conflict=1; load 0x300 -> ld_conflict=0.
